// File: rtl/vga_sync_decoder.sv
// VGA timing receiver: synchronises hsync/vsync/RGB, measures line and frame length,
// locks onto the expected timing and recovers pixel coordinates and colour.
module vga_sync_decoder #(
    parameter int HTOTAL      = 832,
    parameter int VTOTAL      = 520,
    parameter int HSTART      = 168,
    parameter int VSTART      = 31,
    parameter int HACTIVE     = 640,
    parameter int VACTIVE     = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       red_in,
    input  logic       green_in,
    input  logic       blue_in,
    output logic [9:0] x_px,
    output logic [9:0] y_px,
    output logic       activevideo,
    output logic [2:0] color_px,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines
);
    localparam logic [9:0] H_LAST = 10'(HTOTAL - 1);
    localparam logic [9:0] H_MISS = 10'(HTOTAL + 16);
    localparam logic [9:0] V_LAST = 10'(VTOTAL - 1);
    localparam logic [9:0] V_MISS = 10'(VTOTAL + 4);
    localparam logic [9:0] H_BEG  = 10'(HSTART);
    localparam logic [9:0] H_END  = 10'(HSTART + HACTIVE);
    localparam logic [9:0] V_BEG  = 10'(VSTART);
    localparam logic [9:0] V_END  = 10'(VSTART + VACTIVE);
    localparam int         GW     = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0] G_LAST = GW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] gcnt, gcnt_nxt;
    logic [2:0]    hs_q, vs_q, r_q, g_q, b_q;
    logic [9:0]    hcnt, vcnt;
    logic          vpend;
    logic          hfall, vfall, chk_fail, err, in_win;
    logic [2:0]    rgb_s;

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3ff) ? v : v + 10'd1;
    endfunction

    // Stage 3 of the sync chains feeds the edge detectors; colour gets the same
    // third flop so it stays aligned with counters that update after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q <= 3'b111;
            vs_q <= 3'b111;
            r_q  <= 3'b000;
            g_q  <= 3'b000;
            b_q  <= 3'b000;
        end else begin
            hs_q <= {hs_q[1:0], hsync_in};
            vs_q <= {vs_q[1:0], vsync_in};
            r_q  <= {r_q[1:0], red_in};
            g_q  <= {g_q[1:0], green_in};
            b_q  <= {b_q[1:0], blue_in};
        end
    end

    assign hfall = hs_q[2] & ~hs_q[1];
    assign vfall = vs_q[2] & ~vs_q[1];
    assign rgb_s = {r_q[2], g_q[2], b_q[2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt        <= '0;
            vcnt        <= '0;
            vpend       <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            hcnt <= hfall ? 10'd0 : sat_inc(hcnt);
            if (hfall) begin
                line_len <= sat_inc(hcnt);
                vcnt     <= vpend ? 10'd0 : sat_inc(vcnt);
            end
            if (vfall) begin
                frame_lines <= sat_inc(vcnt);
                vpend       <= 1'b1;
            end else if (hfall) begin
                vpend <= 1'b0;
            end
        end
    end

    assign chk_fail = (hfall && (hcnt != H_LAST)) || (vfall && (vcnt != V_LAST)) ||
                      (hcnt == H_MISS) || (vcnt == V_MISS);

    always_comb begin
        state_nxt = state;
        gcnt_nxt  = gcnt;
        err       = 1'b0;
        case (state)
            SEARCH: begin
                if (vfall) begin
                    state_nxt = MEASURE;
                    gcnt_nxt  = '0;
                end
            end
            MEASURE: begin
                if (chk_fail) begin
                    err       = 1'b1;
                    state_nxt = SEARCH;
                end else if (vfall) begin
                    gcnt_nxt = gcnt + 1'b1;
                    if (gcnt == G_LAST) state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (chk_fail) begin
                    err       = 1'b1;
                    state_nxt = SEARCH;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    assign in_win = (state == LOCKED) && (hcnt >= H_BEG) && (hcnt < H_END) &&
                    (vcnt >= V_BEG) && (vcnt < V_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            gcnt        <= '0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            frame_start <= 1'b0;
            activevideo <= 1'b0;
            x_px        <= '0;
            y_px        <= '0;
            color_px    <= '0;
        end else begin
            state       <= state_nxt;
            gcnt        <= gcnt_nxt;
            locked      <= (state_nxt == LOCKED);
            sync_err    <= err;
            frame_start <= vfall;
            activevideo <= in_win;
            x_px        <= in_win ? hcnt - H_BEG : 10'd0;
            y_px        <= in_win ? vcnt - V_BEG : 10'd0;
            color_px    <= in_win ? rgb_s : 3'b000;
        end
    end
endmodule
